// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion delivering round keys 0..10 under valid/advance handshake
module aes_key_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         advance,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         done
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    state_t       state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic [31:0]  rot, temp, w0n, w1n, w2n, w3n;
    always_comb begin
        rot  = {round_key_q[23:0], round_key_q[31:24]};
        temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
               ^ {RCON[round_q + 4'd1], 24'h0};
        w0n  = round_key_q[127:96] ^ temp;
        w1n  = round_key_q[95:64] ^ w0n;
        w2n  = round_key_q[63:32] ^ w1n;
        w3n  = round_key_q[31:0] ^ w2n;
        state_d     = state_q;
        round_key_d = round_key_q;
        round_d     = round_q;
        done_d      = 1'b0;
        if (state_q == IDLE && start) begin
            state_d     = ACTIVE;
            round_key_d = key;
            round_d     = 4'd0;
        end else if (state_q == ACTIVE && advance) begin
            state_d     = (round_q == 4'd10) ? IDLE : ACTIVE;
            done_d      = (round_q == 4'd10);
            round_key_d = (round_q == 4'd10) ? round_key_q : {w0n, w1n, w2n, w3n};
            round_d     = (round_q == 4'd10) ? round_q : round_q + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_q     <= round_d;
            done_q      <= done_d;
        end
    end
    assign round_key = round_key_q;
    assign round     = round_q;
    assign key_valid = (state_q == ACTIVE);
    assign done      = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed FIPS-197 vectors for aes_key_schedule
module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         reset_n, start, advance;
    logic [127:0] key, round_key;
    logic [3:0]   round;
    logic         key_valid, done;
    int           errors = 0;
    int           checks = 0;
    logic [127:0] k1 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_schedule dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .advance(advance),
        .round_key(round_key), .round(round), .key_valid(key_valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic at(input string tag, input int r);
        check({tag, "_round"}, 128'(round), 128'(r));
        check({tag, "_key"}, round_key, k1[r]);
        check({tag, "_valid"}, 128'(key_valid), 128'd1);
    endtask

    task automatic kick(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic walk(input int lo, input int hi);
        advance = 1'b1;
        for (int r = lo; r < hi; r++) begin
            @(negedge clk);
            at("walk", r + 1);
            check("walk_nodone", 128'(done), 128'd0);
        end
        advance = 1'b0;
    endtask

    initial begin
        int  r;
        bit  fin;
        bit  a;
        reset_n = 1'b0; start = 1'b0; advance = 1'b0; key = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 128'(key_valid), 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_key", round_key, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        reset_n = 1'b1;
        // FIPS-197 full expansion with advance held high
        kick(k1[0]);
        at("fips", 0);
        walk(0, 10);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("fips_done", 128'(done), 128'd1);
        check("fips_done_valid", 128'(key_valid), 128'd0);
        check("fips_hold_key", round_key, k1[10]);
        check("fips_hold_round", 128'(round), 128'd10);
        @(negedge clk);
        check("fips_done_pulse", 128'(done), 128'd0);
        // advance in IDLE is ignored
        advance = 1'b1;
        repeat (3) @(negedge clk);
        advance = 1'b0;
        check("idle_adv_round", 128'(round), 128'd10);
        check("idle_adv_valid", 128'(key_valid), 128'd0);
        check("idle_adv_done", 128'(done), 128'd0);
        // random stall pattern
        kick(k1[0]);
        r = 0; fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            at("stall", r);
            a = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            advance = a;
            @(negedge clk);
            if (a) begin
                if (r == 10) fin = 1'b1;
                else r++;
            end
        end
        advance = 1'b0;
        check("stall_finished", 128'(fin), 128'd1);
        check("stall_done", 128'(done), 128'd1);
        @(negedge clk);
        // start in ACTIVE is ignored
        kick(k1[0]);
        walk(0, 4);
        kick(K2);
        at("ign_start", 4);
        walk(4, 10);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("ign_done", 128'(done), 128'd1);
        @(negedge clk);
        // reset mid-expansion
        kick(k1[0]);
        walk(0, 6);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_valid", 128'(key_valid), 128'd0);
        check("midrst_round", 128'(round), 128'd0);
        check("midrst_key", round_key, 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        kick(k1[0]);
        at("restart", 0);
        walk(0, 10);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        // back-to-back start in the done cycle
        check("b2b_done", 128'(done), 128'd1);
        kick(K2);
        check("b2b_r0_key", round_key, K2);
        check("b2b_r0_round", 128'(round), 128'd0);
        check("b2b_r0_valid", 128'(key_valid), 128'd1);
        advance = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b_r10_key", round_key, K2_10);
        check("b2b_r10_round", 128'(round), 128'd10);
        @(negedge clk);
        advance = 1'b0;
        check("b2b_end_done", 128'(done), 128'd1);
        check("b2b_end_valid", 128'(key_valid), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
